// File: rtl/rv32i_ifetch_queue_if.sv
// Fetch-stage bus bundle: IMEM read channel, branch redirect, IF/ID handshake.
// master = fetch unit, slave = the surrounding pipeline / memory.
interface rv32i_ifetch_queue_if #(
  parameter int IMEM_AW = 5
);
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_rvalid;
  logic [31:0]        imem_rdata;
  logic               br_en;
  logic [31:0]        br_target;
  logic               id_ready;
  logic               if_id_valid;
  logic [31:0]        if_id_ir;
  logic [31:0]        if_id_npc;

  modport master (
    output imem_req, imem_addr, if_id_valid, if_id_ir, if_id_npc,
    input  imem_rvalid, imem_rdata, br_en, br_target, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_id_valid, if_id_ir, if_id_npc,
    output imem_rvalid, imem_rdata, br_en, br_target, id_ready
  );
endinterface

// File: rtl/rv32i_ifetch_queue.sv
// rv32i instruction fetch with a small prefetch queue.
// Owns the word PC, issues one IMEM read per cycle while credit allows,
// queues returned words with their next-PC and hands them to decode.
// A redirect clears the queue and drops any wrong-path response.
module rv32i_ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          IMEM_AW  = 5,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input logic                  clk,
  input logic                  RN,
  rv32i_ifetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc;
  logic [31:0]   tag;
  logic          inflight;
  logic          kill;
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [31:0]   q_ir  [DEPTH];
  logic [31:0]   q_npc [DEPTH];

  logic [CW:0]   used;
  logic          req, push, pop;

  // Credit counts both queued and in-flight words so a response always has a slot.
  assign used = {1'b0, count} + (CW+1)'(inflight);
  assign req  = !RN && !bus.br_en && (used < (CW+1)'(DEPTH));
  // Redirect wins over everything queue-related in the same cycle.
  assign push = bus.imem_rvalid && !kill && !bus.br_en;
  assign pop  = (count != '0) && bus.id_ready && !bus.br_en;

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc[IMEM_AW-1:0];
  assign bus.if_id_valid = (count != '0);
  assign bus.if_id_ir    = q_ir[rptr];
  assign bus.if_id_npc   = q_npc[rptr];

  // PC, request tag, in-flight and kill tracking.
  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      pc       <= RESET_PC;
      tag      <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      inflight <= req;
      kill     <= bus.br_en;
      if (bus.br_en)  pc <= bus.br_target;
      else if (req)   pc <= pc + 32'd1;
      if (req)        tag <= pc;
    end
  end

  // Queue occupancy and pointers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else if (bus.br_en) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the IF/ID outputs read zero.
  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_ir[i]  <= '0;
        q_npc[i] <= '0;
      end
    end else if (push) begin
      q_ir[wptr]  <= bus.imem_rdata;
      q_npc[wptr] <= tag + 32'd1;
    end
  end
endmodule

// File: tb/tb_rv32i_ifetch_queue.sv
// Directed bench for rv32i_ifetch_queue: per-cycle vector table for the
// in-order / back-pressure / redirect paths, hand sequences for reset and
// a random-ready scoreboard run.
module tb_rv32i_ifetch_queue;
  logic clk = 1'b0;
  logic RN  = 1'b1;
  always #5 clk = ~clk;

  rv32i_ifetch_queue_if #(.IMEM_AW(5)) bus ();

  rv32i_ifetch_queue #(.DEPTH(4), .IMEM_AW(5), .RESET_PC(32'd0)) dut (
    .clk (clk),
    .RN  (RN),
    .bus (bus)
  );

  // IMEM model: fixed one-cycle read latency.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    bus.imem_rvalid <= bus.imem_req;
    bus.imem_rdata  <= mem[bus.imem_addr];
  end

  typedef struct {
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        req;
    logic [4:0]  addr;
    logic        vld;
    logic [31:0] ir;
    logic [31:0] npc;
  } vec_t;

  vec_t vecs[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic add(input logic rdy, input logic br, input logic [31:0] tgt,
                     input logic req, input int addr, input logic vld,
                     input int midx, input int npc);
    vec_t v;
    v.rdy = rdy; v.br = br; v.tgt = tgt; v.req = req; v.addr = 5'(addr);
    v.vld = vld; v.ir = mem[midx]; v.npc = 32'(npc);
    vecs.push_back(v);
  endtask

  initial begin
    int cyc;
    int exp_npc;
    logic hold_pend;
    logic [31:0] held_npc;

    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[0]  = 32'h0220_8300;
    mem[1]  = 32'h0220_9380;
    mem[2]  = 32'h0230_a400;
    mem[3]  = 32'h0251_3480;
    mem[25] = 32'h0021_0700;

    bus.id_ready  = 1'b0;
    bus.br_en     = 1'b0;
    bus.br_target = '0;

    // In-order stream, back-pressure fill/drain, two redirects (incl. IMEM wrap).
    add(1,0,0, 1, 0, 0, 0, 0);
    add(1,0,0, 1, 1, 0, 0, 0);
    add(1,0,0, 1, 2, 1, 0, 1);
    add(1,0,0, 1, 3, 1, 1, 2);
    add(1,0,0, 1, 4, 1, 2, 3);
    add(1,0,0, 1, 5, 1, 3, 4);
    add(0,0,0, 1, 6, 1, 4, 5);
    add(0,0,0, 1, 7, 1, 4, 5);
    for (int i = 0; i < 8; i++) add(0,0,0, 0, 8, 1, 4, 5);
    add(1,0,0, 0, 8, 1, 4, 5);
    add(1,0,0, 1, 8, 1, 5, 6);
    add(1,0,0, 1, 9, 1, 6, 7);
    add(1,0,0, 1,10, 1, 7, 8);
    add(1,0,0, 1,11, 1, 8, 9);
    add(1,0,0, 1,12, 1, 9,10);
    add(1,1,25, 0,13, 1,10,11);
    add(1,0,0, 1,25, 0, 0, 0);
    add(1,0,0, 1,26, 0, 0, 0);
    add(1,0,0, 1,27, 1,25,26);
    add(1,0,0, 1,28, 1,26,27);
    add(1,1,30, 0,29, 1,27,28);
    add(1,0,0, 1,30, 0, 0, 0);
    add(1,0,0, 1,31, 0, 0, 0);
    add(1,0,0, 1, 0, 1,30,31);
    add(1,0,0, 1, 1, 1,31,32);
    add(1,0,0, 1, 2, 1, 0,33);
    add(1,0,0, 1, 3, 1, 1,34);

    // Reset state.
    @(negedge clk); @(negedge clk); #1;
    chk("rst req",   32'(bus.imem_req),    0);
    chk("rst valid", 32'(bus.if_id_valid), 0);
    chk("rst ir",    bus.if_id_ir,         0);
    chk("rst npc",   bus.if_id_npc,        0);

    @(negedge clk);
    RN = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      bus.id_ready  = vecs[i].rdy;
      bus.br_en     = vecs[i].br;
      bus.br_target = vecs[i].tgt;
      #1;
      chk($sformatf("c%0d req", i),   32'(bus.imem_req),    32'(vecs[i].req));
      chk($sformatf("c%0d addr", i),  32'(bus.imem_addr),   32'(vecs[i].addr));
      chk($sformatf("c%0d valid", i), 32'(bus.if_id_valid), 32'(vecs[i].vld));
      if (vecs[i].vld) begin
        chk($sformatf("c%0d ir", i),  bus.if_id_ir,  vecs[i].ir);
        chk($sformatf("c%0d npc", i), bus.if_id_npc, vecs[i].npc);
      end
      @(negedge clk);
    end
    bus.br_en = 1'b0;

    // Reset with three entries queued: outputs drop at once, refetch from 0.
    RN = 1'b1; bus.id_ready = 1'b0;
    @(negedge clk);
    RN = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("pre-rst valid", 32'(bus.if_id_valid), 1);
    chk("pre-rst npc",   bus.if_id_npc,        1);
    RN = 1'b1;
    #1;
    chk("mid-rst valid", 32'(bus.if_id_valid), 0);
    chk("mid-rst req",   32'(bus.imem_req),    0);
    chk("mid-rst npc",   bus.if_id_npc,        0);
    @(negedge clk);
    RN = 1'b0; bus.id_ready = 1'b1;
    cyc = 0;
    #1;
    while (!bus.if_id_valid && cyc < 10) begin
      @(negedge clk); #1; cyc++;
    end
    chk("refetch latency", 32'(cyc), 2);
    chk("refetch npc",     bus.if_id_npc, 1);
    chk("refetch ir",      bus.if_id_ir,  mem[0]);

    // Random back-pressure, 100 sequential instructions through a scoreboard.
    @(negedge clk);
    RN = 1'b1;
    @(negedge clk);
    RN = 1'b0;
    exp_npc   = 1;
    hold_pend = 1'b0;
    held_npc  = '0;
    cyc       = 0;
    while (exp_npc <= 100 && cyc < 2000) begin
      bus.id_ready = 1'($urandom_range(0, 1));
      #1;
      if (hold_pend) begin
        chk("hold valid", 32'(bus.if_id_valid), 1);
        chk("hold npc",   bus.if_id_npc,        held_npc);
      end
      if (bus.if_id_valid && bus.id_ready) begin
        chk($sformatf("sb npc %0d", exp_npc), bus.if_id_npc, 32'(exp_npc));
        chk($sformatf("sb ir %0d", exp_npc),  bus.if_id_ir,  mem[(exp_npc-1) & 31]);
        exp_npc++;
      end
      hold_pend = bus.if_id_valid && !bus.id_ready;
      held_npc  = bus.if_id_npc;
      @(negedge clk);
      cyc++;
    end
    chk("sb complete", 32'(exp_npc), 101);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
